pool_relu_writer: RTL
=====================

# pool_relu_writer

Stage directly upstream of the layer buffer RAM. It receives the convolution PE array's output stream, one pixel position per beat with `PE_Num` channel lanes. It applies lane-wise 2×2 stride-2 max pooling followed by ReLU. Each pooled pixel is written into the layer buffer's write port with a sequential address starting at a programmable base.

## Interface
Parameters:
- `dwidth`, 16, width of one signed lane value
- `PE_Num`, 8, number of channel lanes per beat
- `FMAP_W`, 28, conv output width; even, ≥2
- `FMAP_H`, 28, conv output height; even, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a frame; ignored while `busy`=1
- `base_addr`  in  8  first write address, sampled on accepted `start`
- `din_valid`  in  1  input beat valid; ignored while `busy`=0
- `din`  in  `PE_Num*dwidth`  signed lanes; lane k at bits [k*dwidth +: dwidth]
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse with the final write
- `din_st`  out  1  layer buffer write enable
- `layer_buffer_waddr`  out  8  layer buffer write address
- `dout`  out  `PE_Num*dwidth`  pooled, ReLU'd lanes to the layer buffer `din`

## Operation
- States:
  - IDLE: `start`=1 → RUN. Load `wptr`=`base_addr`; clear `col`, `row`.
  - RUN: final beat (row=FMAP_H-1, col=FMAP_W-1) accepted → IDLE at the next edge.
- Input order is row-major. Each accepted beat advances `col`. At col=FMAP_W-1, `col` wraps to 0 and `row` increments. There is no backpressure.
- Even col: beat latched into `hreg`.
- Odd col: `hmax` = lane-wise signed max(`hreg`, `din`).
  - Even row: `hmax` is written to `row_buf[col>>1]`.
  - Odd row: `vmax` = lane-wise signed max(`row_buf[col>>1]`, `hmax`). ReLU is applied per lane: a negative value becomes 0, otherwise unchanged. The result is registered to `dout` with `din_st`=1 and `layer_buffer_waddr`=`wptr`, then `wptr` increments.
- Writes per frame: (FMAP_W/2)*(FMAP_H/2); 196 at defaults. `wptr` wraps modulo 256.
- Max ties select either operand (bit-identical). No saturation is needed; the output width equals the input width.
- `din_valid`=0 in RUN: counters and state hold. Gaps are allowed anywhere, including between the two beats of a pair.

## Timing
- Reset values: `busy`=0, `done`=0, `din_st`=0, `layer_buffer_waddr`=0, `dout`=0, state IDLE, counters 0. `row_buf`/`hreg` are not reset.
- Latency is 1 cycle. A beat accepted at edge N with odd row and odd col yields `din_st`=1 in cycle N+1 (the cycle after edge N). `din_st` is high for exactly one cycle per pooled pixel.
- `busy` rises the cycle after the `start` edge. It falls the cycle after the final beat edge, coincident with the final `din_st` and with `done`=1.
- `start` in the cycle `busy` falls is accepted. The next frame's first beat may follow one cycle later.
- `start` with `busy`=1: no effect on counters, `wptr` or outputs.
- `rst` mid-frame: next cycle, all outputs are at reset values. A pending write is dropped, state returns to IDLE, and beats are ignored until a new `start`.
- `start` and `din_valid` in the same IDLE cycle: the beat is ignored; only `start` takes effect.

## Structure
- Shared package/header: `dwidth`, `PE_Num`, the layer buffer address width (8), and a lane-wise signed max helper function. The helper is shared with any later pooling stage.
- One sub-module, `pool_row_buf`:
  - FMAP_W/2 entries × `PE_Num*dwidth`.
  - One synchronous write port; combinational read of the same index.
  - Register array, not BRAM, because the read and write of the same index must not collide within a cycle.
- Top module holds the FSM, `col`/`row`/`wptr` counters, `hreg`, the max/ReLU datapath and output registers.

## Test plan
- Default params, `base_addr`=0x10, continuous valid, lane k of pixel (r,c) = r*28+c-400 → 196 writes at 0x10..0xD3. Each pooled lane = max(4 inputs) clamped at 0. The first write (pixel (1,1) = -371) gives 0. `done` coincides with the write at 0xD3.
- All lanes -1 except a single +5 at (3,2) lane 7 → only write address base+15 has lane 7 = 5. All other lanes and writes are 0.
- Random `din_valid` gaps (≈40% idle), including between pair beats → write data and addresses identical to the gap-free run. `din_st` count = 196.
- `base_addr`=0xF0 → addresses 0xF0..0xFF, then wrap to 0x00..0xB3.
- `start` pulsed mid-frame → no restart; the frame completes normally. A second `start` on the `busy`-fall cycle runs a back-to-back frame.
- `rst` asserted after 300 beats → next cycle `busy`=`din_st`=`done`=0 and `layer_buffer_waddr`=0. A subsequent `start` plus a full frame reproduces the golden output.

Source files
------------

// File: rtl/pool_relu_writer_pkg.sv
// Shared widths, FSM state type and the lane-wise signed max helper
// used by the pooling stages in front of the layer buffer.
package pool_relu_writer_pkg;

  localparam int dwidth = 16;
  localparam int PE_Num = 8;
  localparam int LB_AW  = 8;
  localparam int BUS_W  = dwidth * PE_Num;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Per-lane signed max; ties return b, which is bit-identical to a.
  function automatic logic [BUS_W-1:0] lane_max(input logic [BUS_W-1:0] a,
                                                 input logic [BUS_W-1:0] b);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int k = 0; k < PE_Num; k++) begin
      if ($signed(a[k*dwidth +: dwidth]) > $signed(b[k*dwidth +: dwidth]))
        r[k*dwidth +: dwidth] = a[k*dwidth +: dwidth];
      else
        r[k*dwidth +: dwidth] = b[k*dwidth +: dwidth];
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Holds the horizontal maxima of one even row, one entry per pooled column.
// Latency: write lands at the clock edge, read of the same index is combinational.
// Backpressure: none; written whenever the owner asserts we.
module pool_row_buf #(
  parameter int DEPTH = 14,
  parameter int WIDTH = pool_relu_writer_pkg::BUS_W,
  parameter int IW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic [WIDTH-1:0] wdat,
  output logic [WIDTH-1:0] rdat
);

  // Flop array so the odd-row read and the even-row write never share a port.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdat;
  end

  assign rdat = mem[idx];

endmodule

// File: rtl/pool_relu_writer.sv
// 2x2 stride-2 lane-wise max pool + ReLU, writing pooled pixels to the layer buffer.
// Latency: 1 cycle from the accepted odd-row/odd-col beat to the din_st write.
// Backpressure: none; beats are taken whenever din_valid is high while busy.
module pool_relu_writer
  import pool_relu_writer_pkg::LB_AW;
  import pool_relu_writer_pkg::state_t;
  import pool_relu_writer_pkg::ST_IDLE;
  import pool_relu_writer_pkg::ST_RUN;
  import pool_relu_writer_pkg::lane_max;
#(
  parameter int dwidth = pool_relu_writer_pkg::dwidth,
  parameter int PE_Num = pool_relu_writer_pkg::PE_Num,
  parameter int FMAP_W = 28,
  parameter int FMAP_H = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LB_AW-1:0]         base_addr,
  input  logic                     din_valid,
  input  logic [PE_Num*dwidth-1:0] din,
  output logic                     busy,
  output logic                     done,
  output logic                     din_st,
  output logic [LB_AW-1:0]         layer_buffer_waddr,
  output logic [PE_Num*dwidth-1:0] dout
);

  localparam int BW     = PE_Num * dwidth;
  localparam int HALF_W = FMAP_W / 2;
  localparam int CW     = $clog2(FMAP_W);
  localparam int RW     = $clog2(FMAP_H);
  localparam int IW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [LB_AW-1:0]  wptr;
  logic [BW-1:0]     hreg;
  logic [BW-1:0]     hmax, vmax, relu, rb_rdat;
  logic [IW-1:0]     rb_idx;
  logic              start_acc, beat, last_beat, rb_we, pix_out;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    beat      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        beat = din_valid;
        if (din_valid && last_beat) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_RUN);
  assign last_beat = (row == RW'(FMAP_H - 1)) && (col == CW'(FMAP_W - 1));
  assign rb_idx    = IW'(col >> 1);
  assign rb_we     = beat && col[0] && !row[0];
  assign pix_out   = beat && col[0] && row[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      wptr <= '0;
    end else if (start_acc) begin
      col  <= '0;
      row  <= '0;
      wptr <= base_addr;
    end else if (beat) begin
      if (col == CW'(FMAP_W - 1)) begin
        col <= '0;
        row <= last_beat ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (pix_out) wptr <= wptr + 1'b1;
    end
  end

  // Left half of each horizontal pair; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (beat && !col[0]) hreg <= din;
  end

  pool_row_buf #(
    .DEPTH (HALF_W),
    .WIDTH (BW),
    .IW    (IW)
  ) u_row_buf (
    .clk  (clk),
    .we   (rb_we),
    .idx  (rb_idx),
    .wdat (hmax),
    .rdat (rb_rdat)
  );

  assign hmax = lane_max(hreg, din);
  assign vmax = lane_max(rb_rdat, hmax);

  always_comb begin
    relu = vmax;
    for (int k = 0; k < PE_Num; k++) begin
      if (vmax[k*dwidth + dwidth - 1]) relu[k*dwidth +: dwidth] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_st             <= 1'b0;
      done               <= 1'b0;
      layer_buffer_waddr <= '0;
      dout               <= '0;
    end else begin
      din_st <= pix_out;
      done   <= beat && last_beat;
      if (pix_out) begin
        layer_buffer_waddr <= wptr;
        dout               <= relu;
      end
    end
  end

endmodule
